// File: rtl/instr_encoder.sv
// instr_encoder: registered RV32I instruction encoder.
// Scatters a full 32-bit immediate into the format chosen by the opcode,
// range-checks it, and presents the word through a valid/ready register.
// Illegal immediates and unknown opcodes produce a NOP with out_err set.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    // 12-bit signed range: bits [31:11] are a pure sign extension.
    function automatic logic fits_12s(input logic [31:0] imm);
        return (imm[31:11] == '0) || (&imm[31:11]);
    endfunction

    // 13-bit signed, even (branch offsets).
    function automatic logic fits_b(input logic [31:0] imm);
        return !imm[0] && ((imm[31:12] == '0) || (&imm[31:12]));
    endfunction

    // 21-bit signed, even (jump offsets).
    function automatic logic fits_j(input logic [31:0] imm);
        return !imm[0] && ((imm[31:20] == '0) || (&imm[31:20]));
    endfunction

    logic             valid_q, valid_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [31:0] enc_word;
    logic        enc_bad;
    logic        accept_in;
    logic        accept_out;

    assign in_ready   = !valid_q || out_ready;
    assign accept_in  = in_valid && in_ready;
    assign accept_out = valid_q && out_ready;

    // Encode the current input fields into a word plus an error flag.
    always_comb begin
        enc_word = NOP_WORD;
        enc_bad  = 1'b0;
        unique case (in_opcode)
            OP_LOAD, OP_JALR: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_bad  = !fits_12s(in_imm);
            end
            OP_ALUI: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_bad  = (in_imm[31:5] != '0);
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    enc_bad  = !fits_12s(in_imm);
                end
            end
            OP_STORE: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_bad  = !fits_12s(in_imm);
            end
            OP_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_bad  = !fits_b(in_imm);
            end
            OP_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_bad  = !fits_j(in_imm);
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                enc_bad  = (in_imm[11:0] != '0);
            end
            OP_ALU: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_bad  = 1'b0;
            end
            default: begin
                enc_word = NOP_WORD;
                enc_bad  = 1'b1;
            end
        endcase
        if (enc_bad) begin
            enc_word = NOP_WORD;
        end
    end

    // Next-state for the output register and handshake counters.
    always_comb begin
        valid_d     = valid_q;
        instr_d     = instr_q;
        err_d       = err_q;
        out_count_d = out_count_q;
        err_count_d = err_count_q;
        if (accept_out) begin
            out_count_d = out_count_q + CNT_W'(1);
            if (err_q) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
        if (accept_in) begin
            valid_d = 1'b1;
            instr_d = enc_word;
            err_d   = enc_bad;
        end else if (accept_out) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            out_count_q <= '0;
            err_count_q <= '0;
        end else begin
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            out_count_q <= out_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_count = out_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed plus random stimulus for instr_encoder,
// checked against an arithmetic reference of the encoding rules and a
// transaction-level model of the output register and counters.
module tb_instr_encoder;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          out_err;
    logic [CW-1:0] out_count;
    logic [CW-1:0] err_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    logic        m_valid = 0;
    logic [31:0] m_instr = 0;
    logic        m_err   = 0;
    int          m_cnt   = 0;
    int          m_ecnt  = 0;

    instr_encoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .out_count(out_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from value ranges and shift/mask arithmetic.
    function automatic void ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] imm,
                                    output logic [31:0] w, output logic e);
        longint s;
        bit ok;
        logic [31:0] o, d, f, r1, r2, g;
        s  = longint'($signed(imm));
        o  = 32'(op);
        d  = 32'(rd) << 7;
        f  = 32'(f3) << 12;
        r1 = 32'(rs1) << 15;
        r2 = 32'(rs2) << 20;
        g  = 32'(f7) << 25;
        ok = 0;
        w  = 0;
        case (op)
            7'h03, 7'h67, 7'h13: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    ok = (imm < 32);
                    w  = o | d | f | r1 | ((imm & 32'h1F) << 20) | g;
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    w  = o | d | f | r1 | ((imm & 32'hFFF) << 20);
                end
            end
            7'h23: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = o | ((imm & 32'h1F) << 7) | f | r1 | r2 | (((imm >> 5) & 32'h7F) << 25);
            end
            7'h63: begin
                ok = (imm % 2 == 0) && (s >= -4096) && (s <= 4095);
                w  = o | f | r1 | r2 | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
            end
            7'h6F: begin
                ok = (imm % 2 == 0) && (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20));
                w  = o | d | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
            end
            7'h37, 7'h17: begin
                ok = ((imm % 4096) == 0);
                w  = o | d | (imm & 32'hFFFFF000);
            end
            7'h33: begin
                ok = 1;
                w  = o | d | f | r1 | r2 | g;
            end
            default: ok = 0;
        endcase
        e = !ok;
        if (!ok) w = 32'h00000013;
    endfunction

    // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic cycle();
        logic exp_rdy, hs_in, hs_out, e;
        logic [31:0] w;
        @(negedge clk);
        exp_rdy = !m_valid || out_ready;
        if (chk_en) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        hs_out = m_valid && out_ready;
        hs_in  = in_valid && exp_rdy;
        ref_enc(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, w, e);
        if (!rst_n) begin
            m_valid = 0; m_instr = 0; m_err = 0; m_cnt = 0; m_ecnt = 0;
        end else begin
            if (hs_out) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                if (m_err) m_ecnt = (m_ecnt + 1) % (1 << CW);
            end
            if (hs_in) begin
                m_valid = 1; m_instr = w; m_err = e;
            end else if (hs_out) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_instr", out_instr, m_instr);
            chk("out_err",   32'(out_err), 32'(m_err));
            chk("out_count", 32'(out_count), 32'(m_cnt));
            chk("err_count", 32'(err_count), 32'(m_ecnt));
        end
    endtask

    task automatic put(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
        in_valid = 1; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0;
        cycle();
        rst_n = 1;
    endtask

    initial begin
        logic [6:0] ops [10];
        ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};
        rst_n = 0; in_valid = 0; out_ready = 1;
        put(7'h33, 0, 0, 0, 0, 0, 0); in_valid = 0;
        cycle();
        chk_en = 1;
        cycle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        rst_n = 1;
        cycle();
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        // Known encodings
        put(7'b0010011, 3'b000, 0, 1, 2, 0, 32'hFFFFFFFF); cycle();
        chk("addi", out_instr, 32'hFFF10093); chk("addi_err", 32'(out_err), 32'd0);
        put(7'b0100011, 3'b010, 0, 0, 2, 3, -32'sd4); cycle();
        chk("sw", out_instr, 32'hFE312E23);
        put(7'b1100011, 3'b000, 0, 0, 1, 2, 32'd8); cycle();
        chk("beq", out_instr, 32'h00208463);
        put(7'b1101111, 3'b000, 0, 1, 0, 0, 32'd2048); cycle();
        chk("jal", out_instr, 32'h001000EF);
        put(7'b0110111, 3'b000, 0, 5, 0, 0, 32'h12345000); cycle();
        chk("lui", out_instr, 32'h123452B7);

        // Illegal immediates
        put(7'b0010011, 3'b000, 0, 1, 2, 0, 32'd2048); cycle();
        chk("addi_big", out_instr, 32'h13); chk("addi_big_err", 32'(out_err), 32'd1);
        put(7'b1100011, 3'b000, 0, 0, 1, 2, 32'd3); cycle();
        chk("beq_odd", out_instr, 32'h13); chk("beq_odd_err", 32'(out_err), 32'd1);
        put(7'b0110111, 3'b000, 0, 5, 0, 0, 32'd1); cycle();
        chk("lui_low", out_instr, 32'h13); chk("lui_low_err", 32'(out_err), 32'd1);
        in_valid = 0; cycle();
        chk("errcnt_3", 32'(err_count), 32'd3);

        // Backpressure then streaming
        do_reset();
        put(7'b0010011, 3'b000, 0, 1, 2, 0, 32'hFFFFFFFF); cycle();
        out_ready = 0;
        put(7'b0100011, 3'b010, 0, 0, 2, 3, -32'sd4);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold", out_instr, 32'hFFF10093);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1;
        cycle(); chk("st_sw", out_instr, 32'hFE312E23);
        put(7'b1100011, 3'b000, 0, 0, 1, 2, 32'd8); cycle();
        chk("st_beq", out_instr, 32'h00208463);
        put(7'b1101111, 3'b000, 0, 1, 0, 0, 32'd2048); cycle();
        chk("st_jal", out_instr, 32'h001000EF);
        put(7'b0110111, 3'b000, 0, 5, 0, 0, 32'h12345000); cycle();
        chk("st_lui", out_instr, 32'h123452B7);
        in_valid = 0; cycle();
        chk("st_count5", 32'(out_count), 32'd5);
        chk("st_drop", 32'(out_valid), 32'd0);
        chk("st_keep", out_instr, 32'h123452B7);

        // Reset while output is held
        out_ready = 0;
        put(7'b0110011, 3'b000, 7'h20, 3, 4, 5, 0); cycle();
        rst_n = 0; cycle();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(out_count), 32'd0);
        chk("mid_rst_ecnt", 32'(err_count), 32'd0);
        rst_n = 1; out_ready = 1; in_valid = 0; cycle();

        // Counter wrap with 4-bit counters
        for (int i = 0; i < 17; i++) begin
            put(7'b0110011, 3'(i), 7'(i), 5'(i), 5'(i + 1), 5'(i + 2), 0); cycle();
        end
        in_valid = 0; cycle();
        chk("wrap_count", 32'(out_count), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
                2: imm = $urandom << $urandom_range(0, 20);
                default: imm = 32'($urandom_range(0, 40));
            endcase
            put(ops[$urandom_range(0, 9)], 3'($urandom), 7'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Registered RV32I instruction encoder: the inverse of the core's immediate decode path. It takes instruction fields plus a full 32-bit immediate value, range-checks the immediate for the opcode's format, scatters its bits into the 32-bit instruction word, and presents the result through a valid/ready output register. It sits between the test-program generator or loader and instruction memory, and produces the words the datapath later decodes.

## Interface
Parameters:
- `CNT_W`, 16 — width of the accepted-instruction and error counters.

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — reset, synchronous and active-low.
- `in_valid` input 1 — input fields valid.
- `in_ready` output 1 — encoder can accept input this cycle.
- `in_opcode` input 7 — the opcode; it selects the format.
- `in_funct3` input 3 — funct3 field.
- `in_funct7` input 7 — funct7 field (R-type; also SRAI/SRLI/SLLI bits [31:25]).
- `in_rd`, `in_rs1`, `in_rs2` input 5 each — register indices.
- `in_imm` input 32 — the full immediate as an unencoded byte offset or value.
- `out_valid` output 1 — `out_instr`/`out_err` valid.
- `out_ready` input 1 — consumer accepts output.
- `out_instr` output 32 — encoded instruction word.
- `out_err` output 1 — immediate out of range, or unsupported opcode.
- `out_count` output CNT_W — output handshakes completed. Wraps.
- `err_count` output CNT_W — output handshakes completed with `out_err`=1. Wraps.

## Operation
- Format is selected by `in_opcode`:
  - 0000011 load, 1100111 JALR, 0010011 ALU-imm: I-type.
  - 0100011: S-type.
  - 1100011: B-type.
  - 1101111: J-type.
  - 0110111 / 0010111: U-type.
  - 0110011: R-type. Ignores `in_imm` and never errors on it.
- Field placement: `rd`→[11:7], `funct3`→[14:12], `rs1`→[19:15], `rs2`→[24:20], opcode→[6:0]. Fields not used by the format are forced to zero.
- Encoding rules and legality checks:
  - I-type: [31:20]=imm[11:0]. Legal iff imm[31:11] are all equal.
  - ALU-imm with funct3 001/101 (shifts): [31:25]=`in_funct7`, [24:20]=imm[4:0]. Legal iff imm[31:5]==0.
  - S-type: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same legality as I-type.
  - B-type: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Legal iff imm[0]==0 and imm[31:12] are all equal.
  - J-type: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Legal iff imm[0]==0 and imm[31:20] are all equal.
  - U-type: [31:12]=imm[31:12]. Legal iff imm[11:0]==0.
  - R-type: [31:25]=`in_funct7`.
- Error handling: on an illegal immediate or an unlisted opcode, `out_instr`=32'h00000013 (NOP) and `out_err`=1. The error is captured per instruction; it is not sticky.
- Counters:
  - `out_count` increments on every `out_valid && out_ready`.
  - `err_count` increments on the same condition when `out_err`=1.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset (`rst_n`=0 at a clock edge): `out_valid`=0, `out_instr`=0, `out_err`=0, `out_count`=0, `err_count`=0. `in_ready` is combinational and reads 1 one cycle after reset.
- Reset mid-transfer discards the held output. No handshake is counted in the reset cycle.
- `in_ready` = !`out_valid` || `out_ready` (combinational).
- Input handshake occurs when `in_valid && in_ready`. The encoded word appears on `out_instr` with `out_valid`=1 at the next edge, so latency is 1 cycle.
- Simultaneous output accept and new input: the output register reloads in the same edge. This gives full throughput of 1 instruction/cycle.
- Backpressure: while `out_valid` && !`out_ready`, `out_instr`, `out_err` and `out_valid` hold stable, and `in_ready`=0.
- When output is accepted and there is no new input, `out_valid` drops to 0 at the next edge. `out_instr` holds its last value.
- The encode logic is combinational from the input fields into the output register. There is no state machine beyond the output valid bit and the counters.

## Test plan
- ADDI x1,x2,-1 (opcode 0010011, f3 000, rd 1, rs1 2, imm 32'hFFFFFFFF) -> next cycle `out_instr`=32'hFFF10093, `out_err`=0.
- SW x3,-4(x2) (0100011, f3 010, rs1 2, rs2 3, imm -4) -> 32'hFE312E23.
- BEQ x1,x2,+8 -> 32'h00208463. JAL x1,+2048 -> 32'h001000EF. LUI x5,32'h12345000 -> 32'h123452B7.
- Illegal immediates each give 32'h00000013, `out_err`=1 and `err_count` +1 after the handshake:
  - ADDI with imm 2048.
  - BEQ with imm 3.
  - LUI with imm 32'h00000001.
- Backpressure: hold `out_ready`=0 for 3 cycles while `in_valid`=1 -> `in_ready`=0, `out_instr` is stable, and no input is lost. Then stream 4 back-to-back words with `out_ready`=1 -> 4 consecutive outputs in order, `out_count`=5.
- Assert `rst_n`=0 while `out_valid`=1 -> after the edge, `out_valid`=0 and both counters are 0. Counter wrap: with CNT_W=4, 17 handshakes -> `out_count`=1.
